// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer between the PC register and a
// variable-latency instruction memory. One outstanding request at a time;
// the fetched word is offered to decode with valid/ready and pc_en pulses
// on accept so the PC register advances.
// Optional feature: define INSTR_FETCH_BYPASS_EN to forward the memory
// response straight to decode in the cycle it arrives.
module instr_fetch_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [16:0] TIMEOUT_X = 17'(TIMEOUT);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_stall_cnt;
  logic [15:0] r_wait_cnt;
  logic        r_fetch_err;

  logic        w_req_hs;
  logic        w_rsp_take;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic        w_pc_en;
  logic [16:0] w_wait_inc;

  // Next-state decode and decode-side handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next        = r_state;
    w_req_hs      = 1'b0;
    w_rsp_take    = 1'b0;
    w_instr_valid = 1'b0;
    w_instr       = r_instr;
    case (r_state)
      S_REQ: begin
        w_req_hs = imem_req_ready;
        if (imem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_rsp_take = 1'b1;
`ifdef INSTR_FETCH_BYPASS_EN
          w_instr_valid = 1'b1;
          w_instr       = imem_rsp_data;
          w_next        = instr_ready ? S_REQ : S_HOLD;
`else
          w_next = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        w_instr_valid = 1'b1;
        if (instr_ready) w_next = S_REQ;
      end
      default: w_next = S_REQ;
    endcase
  end

  assign w_pc_en    = w_instr_valid & instr_ready;
  assign w_wait_inc = {1'b0, r_wait_cnt} + 17'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= S_REQ;
    else        r_state <= w_next;
  end

  // Fetch address and instruction capture.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, because decode and the error
    // path observe them directly from the first cycle after reset.
    if (!rst_n) begin
      r_instr_pc <= '0;
      r_instr    <= '0;
    end else begin
      if (w_req_hs)   r_instr_pc <= pc;
      if (w_rsp_take) r_instr    <= imem_rsp_data;
    end
  end

  // Response wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT && r_wait_cnt != TIMEOUT_W) begin
        r_wait_cnt <= w_wait_inc[15:0];
      end
      if (r_state == S_WAIT && !imem_rsp_valid && w_wait_inc >= TIMEOUT_X) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  // Saturating count of cycles without an accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_stall_cnt <= '0;
    else if (!w_pc_en && r_stall_cnt != '1)    r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = pc;
  assign instr_valid    = w_instr_valid;
  assign instr          = w_instr;
  assign instr_pc       = r_instr_pc;
  assign pc_en          = w_pc_en;
  assign fetch_err      = r_fetch_err;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl. The bench plays the PC register,
// the instruction memory and decode; each instruction is described by
// (request stall a, memory latency L, decode backpressure b) and the bench
// predicts every cycle's visible behaviour from those numbers.
module tb_instr_fetch_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;

`ifdef INSTR_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;
  logic [31:0] stall_cnt;

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_stall;
  logic        exp_err;

  instr_fetch_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_en          (pc_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_err      (fetch_err),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment PC register: advances by one instruction on pc_en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= 32'd0;
    else if (pc_en) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One instruction. Called at the start of a cycle with the DUT in REQ.
  // a: cycles with imem_req_ready low before the handshake.
  // lat: memory latency (response in the lat-th WAIT cycle).
  // b: cycles in which the instruction is offered but decode is not ready.
  task automatic run_instr(input int a, input int lat, input int b, input logic [31:0] data);
    int          cyc = 0;
    int          h;
    logic [31:0] exp_ipc;
    logic        err_before;

    err_before = exp_err;
    // REQ phase: stall, then handshake; spurious responses must be ignored.
    for (int i = 0; i <= a; i++) begin
      imem_req_ready = (i == a);
      imem_rsp_valid = (i < a) ? 1'($urandom_range(1)) : 1'b0;
      imem_rsp_data  = $urandom;
      instr_ready    = 1'($urandom_range(1));
      #1;
      check("req_valid", 32'(imem_req_valid), 32'd1);
      check("req_addr", imem_req_addr, exp_pc);
      check("req_no_valid", 32'(instr_valid), 32'd0);
      check("req_pc_en", 32'(pc_en), 32'd0);
      next_cycle();
      cyc++;
    end
    exp_ipc = exp_pc;

    // WAIT phase: response arrives in the last cycle.
    for (int k = 0; k < lat; k++) begin
      imem_req_ready = 1'($urandom_range(1));
      imem_rsp_valid = (k == lat - 1);
      imem_rsp_data  = (k == lat - 1) ? data : $urandom;
      instr_ready    = (BYPASS && k == lat - 1) ? (b == 0) : 1'($urandom_range(1));
      #1;
      check("wait_req_valid", 32'(imem_req_valid), 32'd0);
      check("wait_pc_en", 32'(pc_en), 32'(BYPASS && k == lat - 1 && b == 0));
      check("wait_instr_valid", 32'(instr_valid), 32'(BYPASS && k == lat - 1));
      if (BYPASS && k == lat - 1) check("bypass_instr", instr, data);
      if (k == 0) check("wait_err_early", 32'(fetch_err), 32'(err_before));
      if (k == lat - 1 && lat >= int'(TB_TIMEOUT) + 2) check("timeout_err", 32'(fetch_err), 32'd1);
      next_cycle();
      cyc++;
    end

    // HOLD phase: instruction offered and stable until accepted.
    h = BYPASS ? b : b + 1;
    for (int j = 0; j < h; j++) begin
      imem_req_ready = 1'($urandom_range(1));
      imem_rsp_valid = 1'($urandom_range(1));
      imem_rsp_data  = $urandom;
      instr_ready    = (j == h - 1);
      #1;
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, data);
      check("hold_instr_pc", instr_pc, exp_ipc);
      check("hold_req_valid", 32'(imem_req_valid), 32'd0);
      check("hold_pc_en", 32'(pc_en), 32'(j == h - 1));
      next_cycle();
      cyc++;
    end

    // Exactly one accept per instruction; every other cycle is a stall.
    exp_pc    = exp_pc + 32'd4;
    exp_stall = exp_stall + 32'(cyc - 1);
    if (lat > int'(TB_TIMEOUT)) exp_err = 1'b1;
    check("stall_cnt", stall_cnt, exp_stall);
    check("fetch_err", 32'(fetch_err), 32'(exp_err));
    check("pc_advanced", pc, exp_pc);
    check("instr_pc_latched", instr_pc, exp_ipc);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_pc"}, instr_pc, 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    instr_ready    = 1'b0;
    exp_pc         = 32'd0;
    exp_stall      = 32'd0;
    exp_err        = 1'b0;

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;

    // Streaming: L=1, no stalls, NOP instructions at 0, 4, 8.
    for (int n = 0; n < 3; n++) run_instr(0, 1, 0, 32'h0000_0013);

    // Decode backpressure for 5 cycles, then a single accept.
    run_instr(0, 2, 5, 32'hDEAD_BEEF);

    // Request stall for 4 cycles with spurious responses around.
    run_instr(4, 1, 1, 32'h1234_5678);

    // Randomized traffic.
    for (int n = 0; n < 20; n++) begin
      run_instr(int'($urandom_range(3)), int'($urandom_range(3, 1)),
                int'($urandom_range(3)), $urandom);
    end

    // Timeout: response only after 10 WAIT cycles; flag is sticky.
    run_instr(0, 10, 1, 32'hCAFE_F00D);
    run_instr(1, 1, 0, 32'h0BAD_F00D);

    // Reset asserted in the middle of WAIT.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    next_cycle();
    imem_req_ready = 1'b0;
    next_cycle();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_wait_rst");
    next_cycle();
    rst_n     = 1'b1;
    exp_pc    = 32'd0;
    exp_stall = 32'd0;
    exp_err   = 1'b0;

    // After release: fetch restarts at 0, a late response in REQ is dropped.
    run_instr(2, 1, 0, 32'h0000_0093);
    run_instr(0, 3, 2, $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
